// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, one-outstanding imem request,
// PC-tagged instruction queue, redirect with in-flight squash.
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter int              INST_BYTES = 4,
  parameter int              DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_ack,
  input  logic [XLEN-1:0]          imem_rdata,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [XLEN-1:0]          inst_data,
  output logic [XLEN-1:0]          inst_pc,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] INC = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(INC - XLEN'(1));

  typedef enum logic {
    FETCH,
    KILL
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [XLEN-1:0] data_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q   [DEPTH];

  logic ack;
  logic held;
  logic push;
  logic pop;

  always_comb begin
    ack     = req_q && imem_ack;
    held    = req_q && !imem_ack;
    pop     = (count_q != '0) && inst_ready;
    push    = ack && (state_q == FETCH) && !redirect_valid;
    state_d = state_q;
    pc_d    = pc_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    req_d   = 1'b0;
    addr_d  = addr_q;

    if (redirect_valid) begin
      pc_d    = redirect_pc & ALIGN_MASK;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      state_d = held ? KILL : FETCH;
    end else begin
      if (push) begin
        pc_d = pc_q + INC;
      end
      if (state_q == KILL && ack) begin
        state_d = FETCH;
      end
      wptr_d  = wptr_q + PW'(push);
      rptr_d  = rptr_q + PW'(pop);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    // a raised request is never withdrawn before its ack
    if (held) begin
      req_d  = 1'b1;
      addr_d = addr_q;
    end else begin
      req_d  = (state_d == FETCH) && fetch_en
               && (count_d < CW'(DEPTH));
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      data_mem_q[wptr_q] <= imem_rdata;
      pc_mem_q[wptr_q]   <= addr_q;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign inst_valid  = (count_q != '0);
  assign inst_data   = data_mem_q[rptr_q];
  assign inst_pc     = pc_mem_q[rptr_q];
  assign queue_count = count_q;

endmodule
